// File: rtl/pe3x3_ctrl_if.sv
// Bus bundle between pe3x3_ctrl, the fmap memory, the PE row and the downstream consumer.
interface pe3x3_ctrl_if #(
  parameter int unsigned OUTPUT_NUM = 9,
  parameter int unsigned W          = 32
);
  logic                      fmap_rd_o;
  logic [7:0]                fmap_addr_o;
  logic [1:0]                wht_sel_o;
  logic                      pe_config_o;
  logic [OUTPUT_NUM*W-1:0]   pe_res_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [7:0]                out_row_o;
  logic [OUTPUT_NUM*W-1:0]   out_data_o;

  modport master (
    output fmap_rd_o, fmap_addr_o, wht_sel_o, pe_config_o,
    output out_valid_o, out_row_o, out_data_o,
    input  pe_res_i, out_ready_i
  );

  modport slave (
    input  fmap_rd_o, fmap_addr_o, wht_sel_o, pe_config_o,
    input  out_valid_o, out_row_o, out_data_o,
    output pe_res_i, out_ready_i
  );
endinterface

// File: rtl/pe3x3_ctrl.sv
// 3x3 PE row controller: issues three fmap/kernel rows per output row, accumulates the
// registered PE results lane-wise (mod 2^W) and hands each row out over valid/ready.
// Optional macro PE3X3_CTRL_RELU_EN clamps negative output lanes to zero.
module pe3x3_ctrl #(
  parameter int unsigned IW         = 24,
  parameter int unsigned FW         = 8,
  parameter int unsigned OUTPUT_NUM = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [7:0]       rows_i,
  input  logic             united_i,
  pe3x3_ctrl_if.master     bus,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int unsigned W  = IW + FW;
  localparam int unsigned DW = OUTPUT_NUM * W;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, DONE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    rows_q, rows_d;
  logic          united_q, united_d;
  logic [1:0]    vld_q, vld_d;
  logic [1:0]    kp1_q, kp1_d, kp2_q, kp2_d;
  logic [DW-1:0] acc_q, acc_d;

  logic          fmap_rd_q, fmap_rd_d;
  logic [7:0]    fmap_addr_q, fmap_addr_d;
  logic [1:0]    wht_sel_q, wht_sel_d;
  logic          pe_config_q, pe_config_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_row_q, out_row_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [8:0]    r_inc, rows_m2;

  assign r_inc   = 9'(r_q) + 9'd1;
  assign rows_m2 = 9'(rows_q) - 9'd2;

  // Job sequencing; registered outputs are derived from the next-state values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    rows_d   = rows_q;
    united_d = united_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (rows_i >= 8'd3) begin
            rows_d   = rows_i;
            united_d = united_i;
            r_d      = 8'd0;
            cnt_d    = 2'd0;
            state_d  = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == 2'd2) begin
          cnt_d   = 2'd0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DRAIN: begin
        if (cnt_q == 2'd1) begin
          cnt_d   = 2'd0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      OUT: begin
        if (bus.out_ready_i) begin
          if (r_inc < rows_m2) begin
            r_d     = r_q + 8'd1;
            cnt_d   = 2'd0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    fmap_rd_d   = (state_d == ISSUE);
    wht_sel_d   = (state_d == ISSUE) ? cnt_d : 2'd0;
    fmap_addr_d = (state_d == ISSUE) ? (r_d + 8'(cnt_d)) : 8'd0;
    pe_config_d = busy_d ? united_d : 1'b0;
    out_valid_d = (state_d == OUT);
    out_row_d   = r_d;
  end

  // Result pipeline: PE data for an issue arrives two cycles later; k=0 reloads, k=1/2 add.
  always_comb begin
    vld_d = {vld_q[0], fmap_rd_q};
    kp1_d = wht_sel_q;
    kp2_d = kp1_q;
    acc_d = acc_q;
    if (vld_q[1]) begin
      for (int l = 0; l < int'(OUTPUT_NUM); l++) begin
        if (kp2_q == 2'd0) acc_d[l*W +: W] = bus.pe_res_i[l*W +: W];
        else               acc_d[l*W +: W] = acc_q[l*W +: W] + bus.pe_res_i[l*W +: W];
      end
    end
  end

  // Output lane view of the accumulators.
  always_comb begin
    out_data_d = acc_d;
`ifdef PE3X3_CTRL_RELU_EN
    for (int l = 0; l < int'(OUTPUT_NUM); l++) begin
      if (acc_d[l*W + W - 1]) out_data_d[l*W +: W] = '0;
    end
`endif
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      r_q         <= 8'd0;
      rows_q      <= 8'd0;
      united_q    <= 1'b0;
      vld_q       <= 2'd0;
      kp1_q       <= 2'd0;
      kp2_q       <= 2'd0;
      acc_q       <= '0;
      fmap_rd_q   <= 1'b0;
      fmap_addr_q <= 8'd0;
      wht_sel_q   <= 2'd0;
      pe_config_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= 8'd0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      rows_q      <= rows_d;
      united_q    <= united_d;
      vld_q       <= vld_d;
      kp1_q       <= kp1_d;
      kp2_q       <= kp2_d;
      acc_q       <= acc_d;
      fmap_rd_q   <= fmap_rd_d;
      fmap_addr_q <= fmap_addr_d;
      wht_sel_q   <= wht_sel_d;
      pe_config_q <= pe_config_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.fmap_rd_o   = fmap_rd_q;
  assign bus.fmap_addr_o = fmap_addr_q;
  assign bus.wht_sel_o   = wht_sel_q;
  assign bus.pe_config_o = pe_config_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_row_o   = out_row_q;
  assign bus.out_data_o  = out_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_pe3x3_ctrl.sv
// Directed bench for pe3x3_ctrl with a behavioural fmap memory + PE register model.
module tb_pe3x3_ctrl;
  localparam int unsigned N = 9;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic united = 1'b0;
  logic ready = 1'b0;
  logic [7:0] rows = 8'd0;
  logic busy, done, err;

  int vec = 0;
  int errs = 0;

  logic vary = 1'b0;
  logic [31:0] lane_base = 32'd0;
  logic s1_v = 1'b0;
  logic [7:0] s1_a = 8'd0;
  logic [N*W-1:0] pe_res = '0;

  pe3x3_ctrl_if #(.OUTPUT_NUM(N), .W(W)) bus ();
  assign bus.pe_res_i    = pe_res;
  assign bus.out_ready_i = ready;

  pe3x3_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .rows_i   (rows),
    .united_i (united),
    .bus      (bus),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  // Memory (1 cycle) then PE register (1 cycle); junk when no issue is in flight.
  always @(posedge clk) begin
    s1_v <= bus.fmap_rd_o;
    s1_a <= bus.fmap_addr_o;
    for (int l = 0; l < int'(N); l++) begin
      if (!s1_v)     pe_res[l*W +: W] <= 32'h0BAD0BAD;
      else if (vary) pe_res[l*W +: W] <= ((32'(s1_a) + 32'd1) << 8) + 32'(l);
      else           pe_res[l*W +: W] <= lane_base;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({bus.fmap_rd_o, bus.fmap_addr_o, bus.wht_sel_o, bus.pe_config_o, bus.out_valid_o,
         bus.out_row_o, busy, done, err} !== 24'd0) begin
      errs++;
      $display("FAIL reset_ctrl got rd=%b addr=%h sel=%h cfg=%b v=%b row=%h busy=%b done=%b err=%b want all 0",
               bus.fmap_rd_o, bus.fmap_addr_o, bus.wht_sel_o, bus.pe_config_o, bus.out_valid_o,
               bus.out_row_o, busy, done, err);
    end
    vec++;
    if (bus.out_data_o !== '0) begin
      errs++;
      $display("FAIL reset_data got %h want 0", bus.out_data_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one job with ready=1 and checks the cycle-by-cycle schedule.
  task automatic test_stream(input int nrows_in, input logic uni, input logic vry,
                             input logic [31:0] base, input logic [31:0] exp_c);
    int nout;
    logic [31:0] expv;
    vary = vry;
    lane_base = base;
    ready = 1'b1;
    start = 1'b1;
    rows = 8'(nrows_in);
    united = uni;
    @(negedge clk);
    start = 1'b0;
    nout = nrows_in - 2;
    for (int t = 0; t <= 6 * nout; t++) begin
      int ph;
      int r;
      ph = t % 6;
      r = t / 6;
      if (t == 6 * nout) begin
        vec++;
        if (done !== 1'b1 || busy !== 1'b1 || bus.fmap_rd_o !== 1'b0) begin
          errs++;
          $display("FAIL done_pulse t=%0d got done=%b busy=%b rd=%b want 1 1 0", t, done, busy, bus.fmap_rd_o);
        end
      end else begin
        vec++;
        if (bus.fmap_rd_o !== (ph < 3) || done !== 1'b0 || busy !== 1'b1 || bus.pe_config_o !== uni) begin
          errs++;
          $display("FAIL sched t=%0d got rd=%b done=%b busy=%b cfg=%b want rd=%b done=0 busy=1 cfg=%b",
                   t, bus.fmap_rd_o, done, busy, bus.pe_config_o, (ph < 3), uni);
        end
        vec++;
        if (ph < 3) begin
          if (bus.fmap_addr_o !== 8'(r + ph) || bus.wht_sel_o !== 2'(ph)) begin
            errs++;
            $display("FAIL issue t=%0d got addr=%0d sel=%0d want addr=%0d sel=%0d",
                     t, bus.fmap_addr_o, bus.wht_sel_o, r + ph, ph);
          end
        end else if (bus.wht_sel_o !== 2'd0) begin
          errs++;
          $display("FAIL sel_idle t=%0d got %0d want 0", t, bus.wht_sel_o);
        end
        vec++;
        if (bus.out_valid_o !== (ph == 5)) begin
          errs++;
          $display("FAIL valid t=%0d got %b want %b", t, bus.out_valid_o, (ph == 5));
        end
        if (ph == 5) begin
          vec++;
          if (bus.out_row_o !== 8'(r)) begin
            errs++;
            $display("FAIL out_row t=%0d got %0d want %0d", t, bus.out_row_o, r);
          end
          for (int l = 0; l < int'(N); l++) begin
            expv = vry ? ((32'(3 * r + 6) << 8) + 32'(3 * l)) : exp_c;
            vec++;
            if (bus.out_data_o[l*W +: W] !== expv) begin
              errs++;
              $display("FAIL out_data row=%0d lane=%0d got %h want %h", r, l, bus.out_data_o[l*W +: W], expv);
            end
          end
        end
      end
      @(negedge clk);
    end
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL job_end got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_stall();
    logic [N*W-1:0] expd;
    expd = {N{32'h0000_0300}};
    vary = 1'b0;
    lane_base = 32'h0000_0100;
    ready = 1'b0;
    start = 1'b1;
    rows = 8'd3;
    united = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      vec++;
      if (bus.out_valid_o !== 1'b1 || bus.fmap_rd_o !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
        errs++;
        $display("FAIL stall_ctrl i=%0d got v=%b rd=%b err=%b done=%b want 1 0 0 0",
                 i, bus.out_valid_o, bus.fmap_rd_o, err, done);
      end
      vec++;
      if (bus.out_data_o !== expd) begin
        errs++;
        $display("FAIL stall_data i=%0d got %h want %h", i, bus.out_data_o, expd);
      end
      if (i == 0) begin
        start = 1'b1;
        rows = 8'd7;
      end
      if (i == 5) start = 1'b0;
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus.out_valid_o !== 1'b0 || done !== 1'b1) begin
      errs++;
      $display("FAIL stall_release got v=%b done=%b want 0 1", bus.out_valid_o, done);
    end
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || bus.fmap_rd_o !== 1'b0) begin
      errs++;
      $display("FAIL busy_start_ignored got busy=%b rd=%b want 0 0", busy, bus.fmap_rd_o);
    end
  endtask

  task automatic test_err();
    start = 1'b1;
    rows = 8'd2;
    @(negedge clk);
    start = 1'b0;
    vec++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL err_pulse got err=%b busy=%b want 1 0", err, busy);
    end
    @(negedge clk);
    vec++;
    if (err !== 1'b0 || busy !== 1'b0 || bus.fmap_rd_o !== 1'b0) begin
      errs++;
      $display("FAIL err_after got err=%b busy=%b rd=%b want 0 0 0", err, busy, bus.fmap_rd_o);
    end
  endtask

  task automatic test_wrap();
`ifdef PE3X3_CTRL_RELU_EN
    test_stream(3, 1'b0, 1'b0, 32'hFFFF_FF00, 32'h0000_0000);
`else
    test_stream(3, 1'b0, 1'b0, 32'hFFFF_FF00, 32'hFFFF_FD00);
`endif
    test_stream(3, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFD);
  endtask

  task automatic test_reset_mid();
    vary = 1'b0;
    lane_base = 32'h0000_0100;
    ready = 1'b1;
    start = 1'b1;
    rows = 8'd4;
    united = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({bus.fmap_rd_o, bus.fmap_addr_o, bus.wht_sel_o, bus.pe_config_o, bus.out_valid_o,
         bus.out_row_o, busy, done, err} !== 24'd0) begin
      errs++;
      $display("FAIL midreset_ctrl got rd=%b addr=%h cfg=%b v=%b row=%h busy=%b want all 0",
               bus.fmap_rd_o, bus.fmap_addr_o, bus.pe_config_o, bus.out_valid_o, bus.out_row_o, busy);
    end
    vec++;
    if (bus.out_data_o !== '0) begin
      errs++;
      $display("FAIL midreset_data got %h want 0", bus.out_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_stream(3, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0300);
  endtask

  initial begin
    test_reset();
    test_stream(3, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0300);
    test_stream(5, 1'b0, 1'b1, 32'h0, 32'h0);
    test_stall();
    test_err();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
